// File: rtl/instruction_fetch_responder.sv
// Fetch-side instruction memory responder.
// Fixed-latency word reads with abort, misalignment flag and a load port.
module instruction_fetch_responder #(
    parameter int N           = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    input  logic [N-1:0]      reqAddr,
    input  logic              abort,
    output logic              respValid,
    output logic [N-1:0]      respInstruction,
    output logic [N-1:0]      respAddr,
    output logic              misaligned,
    output logic              busy,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [N-1:0]      loadData
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic [N-1:0]      addr_q;
    logic [N-1:0]      addr_nx;
    logic              accept;
    logic              capture;
    logic [N-1:0]      cap_addr;
    logic [ADDR_W-1:0] cap_idx;
    logic [N-1:0]      rd_word;
    logic [N-1:0]      mem [DEPTH];

    // Backing array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end
    end

    // Next state: abort beats acceptance, WAIT counts down to the RESP entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        accept   = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (reqValid) begin
                    accept  = 1'b1;
                    addr_nx = reqAddr;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        capture  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_CYCLES);
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nx = RESP;
                        capture  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Read path: zero-wait requests read straight from reqAddr; a load to
    // the same word on the capture edge is forwarded.
    always_comb begin
        cap_addr = accept ? reqAddr : addr_q;
        cap_idx  = cap_addr[ADDR_W+1:2];
        rd_word  = mem[cap_idx];
        if (loadEn && (loadAddr == cap_idx)) begin
            rd_word = loadData;
        end
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            addr_q          <= '0;
            respValid       <= 1'b0;
            respInstruction <= '0;
            respAddr        <= '0;
            misaligned      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_q    <= addr_nx;
            respValid <= capture;
            if (capture) begin
                respAddr   <= cap_addr;
                misaligned <= |cap_addr[1:0];
                if (|cap_addr[1:0]) begin
                    respInstruction <= '0;
                end else begin
                    respInstruction <= rd_word;
                end
            end
        end
    end

    assign busy = (state == WAIT);

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: two instances (zero and two
// wait states) checked every cycle against a timestamp-based model.
module tb_instruction_fetch_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid;
    logic [31:0]   reqAddr;
    logic          abort;
    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [31:0]   loadData;

    logic          rv   [2];
    logic [31:0]   ri   [2];
    logic [31:0]   ra   [2];
    logic          mis  [2];
    logic          bsy  [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch_responder #(
        .N(32), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(0)
    ) u0 (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqAddr(reqAddr),
        .abort(abort), .respValid(rv[0]), .respInstruction(ri[0]),
        .respAddr(ra[0]), .misaligned(mis[0]), .busy(bsy[0]),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    instruction_fetch_responder #(
        .N(32), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(2)
    ) u2 (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqAddr(reqAddr),
        .abort(abort), .respValid(rv[1]), .respInstruction(ri[1]),
        .respAddr(ra[1]), .misaligned(mis[1]), .busy(bsy[1]),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a request accepted at edge k is delivered at edge k+W,
    // unless an abort or reset arrives at or before that edge.
    int          wv [2] = '{0, 2};
    logic [31:0] mmem [DEPTH];
    int          edge_n = 0;
    bit          pend [2];
    int          due  [2];
    logic [31:0] paddr[2];
    logic        e_v  [2];
    logic [31:0] e_i  [2];
    logic [31:0] e_a  [2];
    logic        e_m  [2];
    logic        e_b  [2];
    bit          chk_en = 0;

    initial begin
        for (int k = 0; k < DEPTH; k++) mmem[k] = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; due[i] = 0; paddr[i] = '0;
            e_v[i] = 0; e_i[i] = '0; e_a[i] = '0; e_m[i] = 0; e_b[i] = 0;
        end
    end

    always @(posedge clk) begin
        bit          fire;
        logic [31:0] fa;
        edge_n++;
        if (loadEn) mmem[loadAddr] = loadData;
        for (int i = 0; i < 2; i++) begin
            fire = 0;
            fa   = '0;
            if (rst) begin
                pend[i] = 0;
                e_v[i] = 0; e_i[i] = '0; e_a[i] = '0; e_m[i] = 0;
            end else begin
                if (pend[i]) begin
                    if (abort) begin
                        pend[i] = 0;
                    end else if (edge_n == due[i]) begin
                        pend[i] = 0;
                        fire    = 1;
                        fa      = paddr[i];
                    end
                end else if (reqValid && !abort) begin
                    if (wv[i] == 0) begin
                        fire = 1;
                        fa   = reqAddr;
                    end else begin
                        pend[i]  = 1;
                        due[i]   = edge_n + wv[i];
                        paddr[i] = reqAddr;
                    end
                end
                e_v[i] = fire;
                if (fire) begin
                    e_a[i] = fa;
                    e_m[i] = (fa % 4) != 0;
                    e_i[i] = e_m[i] ? 32'h0 : mmem[(fa / 4) % DEPTH];
                end
            end
            e_b[i] = pend[i];
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d respValid", i), 32'(rv[i]), 32'(e_v[i]));
                chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(e_b[i]));
                chk($sformatf("u%0d misaligned", i), 32'(mis[i]), 32'(e_m[i]));
                chk($sformatf("u%0d respInstruction", i), ri[i], e_i[i]);
                chk($sformatf("u%0d respAddr", i), ra[i], e_a[i]);
            end
        end
    end

    // Wait (bounded) for the two-wait-state instance to respond.
    task automatic wait_resp(input int limit, output int waited, output bit ok);
        ok     = 0;
        waited = 0;
        while (!ok && waited < limit) begin
            @(negedge clk);
            waited++;
            if (rv[1] === 1'b1) ok = 1;
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_resp: timeout after %0d cycles", limit);
        end
    endtask

    task automatic req_one(input logic [31:0] a, input logic [31:0] ins,
                           input logic m);
        int w;
        bit ok;
        reqValid = 1'b1;
        reqAddr  = a;
        wait_resp(20, w, ok);
        if (ok) begin
            chk("lit latency", 32'(w), 32'd3);
            chk("lit instr", ri[1], ins);
            chk("lit addr", ra[1], a);
            chk("lit misaligned", 32'(mis[1]), 32'(m));
        end
        reqValid = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] words [4] = '{32'hE3A00001, 32'hE3A01002,
                                32'hE0802001, 32'hEAFFFFFE};
    logic [31:0] seq_a [3] = '{32'h0, 32'h4, 32'hC};
    logic [31:0] seq_i [3] = '{32'hE3A00001, 32'hE3A01002, 32'hEAFFFFFE};

    initial begin
        int w;
        bit ok;
        rst = 1'b1; reqValid = 1'b0; reqAddr = '0; abort = 1'b0;
        loadEn = 1'b0; loadAddr = '0; loadData = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("lit reset respValid", 32'(rv[1]), 32'd0);
        chk("lit reset busy", 32'(bsy[1]), 32'd0);
        chk("lit reset instr", ri[1], 32'd0);
        chk("lit reset addr", ra[1], 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            loadEn = 1'b1; loadAddr = AW'(k); loadData = words[k];
            @(negedge clk);
        end
        loadEn = 1'b0;
        @(negedge clk);

        // Single request with latency walk.
        reqValid = 1'b1; reqAddr = 32'h8;
        @(negedge clk);
        chk("lit busy c1", 32'(bsy[1]), 32'd1);
        @(negedge clk);
        chk("lit busy c2", 32'(bsy[1]), 32'd1);
        @(negedge clk);
        chk("lit resp c3", 32'(rv[1]), 32'd1);
        chk("lit resp instr", ri[1], 32'hE0802001);
        chk("lit resp addr", ra[1], 32'h8);
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Held stream, address advanced on each response.
        reqValid = 1'b1; reqAddr = seq_a[0];
        for (int k = 0; k < 3; k++) begin
            wait_resp(20, w, ok);
            if (ok) begin
                chk("lit stream gap", 32'(w), 32'd3);
                chk("lit stream instr", ri[1], seq_i[k]);
            end
            if (k < 2) reqAddr = seq_a[k+1];
            else reqValid = 1'b0;
        end
        @(negedge clk);

        // Abort one cycle after acceptance.
        reqValid = 1'b1; reqAddr = 32'h4;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("lit abort busy", 32'(bsy[1]), 32'd0);
        chk("lit abort resp", 32'(rv[1]), 32'd0);
        abort = 1'b0; reqValid = 1'b0;
        repeat (4) @(negedge clk);
        req_one(32'h0, 32'hE3A00001, 1'b0);

        // Misaligned and wrapped addresses.
        req_one(32'h6, 32'h0, 1'b1);
        req_one(32'h1004, 32'hE3A01002, 1'b0);

        // Load forwarded into the capture edge.
        reqValid = 1'b1; reqAddr = 32'h8;
        @(negedge clk);
        @(negedge clk);
        loadEn = 1'b1; loadAddr = AW'(2); loadData = 32'h12345678;
        @(negedge clk);
        chk("lit fwd resp", 32'(rv[1]), 32'd1);
        chk("lit fwd instr", ri[1], 32'h12345678);
        loadEn = 1'b0; reqValid = 1'b0;
        @(negedge clk);
        req_one(32'h8, 32'h12345678, 1'b0);

        // Reset while waiting.
        reqValid = 1'b1; reqAddr = 32'h0;
        @(negedge clk);
        rst = 1'b1; reqValid = 1'b0;
        @(negedge clk);
        chk("lit rst resp", 32'(rv[1]), 32'd0);
        chk("lit rst busy", 32'(bsy[1]), 32'd0);
        chk("lit rst instr", ri[1], 32'd0);
        chk("lit rst addr", ra[1], 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        req_one(32'h0, 32'hE3A00001, 1'b0);

        // Zero wait states: response the cycle after acceptance.
        reqValid = 1'b1; reqAddr = 32'hC;
        @(negedge clk);
        chk("lit w0 resp", 32'(rv[0]), 32'd1);
        chk("lit w0 instr", ri[0], 32'hEAFFFFFE);
        chk("lit w0 addr", ra[0], 32'hC);
        reqValid = 1'b0;
        repeat (5) @(negedge clk);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
